// File: rtl/rng_key_sampler.sv
// Rejection sampler for ElGamal ephemeral keys: draws RNG words, masks them to the
// bit length of p-2 and accepts the first candidate in [1, p-2], or reports failure.
module rng_key_sampler #(
  parameter int WIDTH     = 64,
  parameter int MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_tvalid,
  output logic             req_tready,
  input  logic [WIDTH-1:0] modulus,
  input  logic             rnd_tvalid,
  input  logic [WIDTH-1:0] rnd,
  output logic             rnd_tready,
  output logic             key_tvalid,
  input  logic             key_tready,
  output logic [WIDTH-1:0] key,
  output logic             fail
);

  // state | meaning
  // IDLE  | waiting for a key request
  // MASK  | derive lim = p-2 and its bit mask, reject p < 3
  // DRAW  | waiting for an RNG word
  // CHECK | range-test the masked candidate
  // DONE  | result presented until key_tready
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MASK  = 3'd1;
  localparam logic [2:0] DRAW  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);
  localparam logic [WIDTH-1:0] P_MIN     = WIDTH'(3);
  localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             fail_q, fail_d;
  logic [TRY_W-1:0] tries_q, tries_d;

  logic [WIDTH-1:0] lim_calc;
  logic [WIDTH-1:0] mask_calc;

  assign lim_calc = p_q - TWO;

  // Highest set bit of lim wins, giving 2^n-1 for n = bit length of lim.
  always_comb begin
    mask_calc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lim_calc[i]) mask_calc = {WIDTH{1'b1}} >> (WIDTH - 1 - i);
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    lim_d   = lim_q;
    mask_d  = mask_q;
    cand_d  = cand_q;
    key_d   = key_q;
    fail_d  = fail_q;
    tries_d = tries_q;
    case (state_q)
      IDLE: begin
        if (req_tvalid) begin
          p_d     = modulus;
          tries_d = '0;
          key_d   = '0;
          fail_d  = 1'b0;
          state_d = MASK;
        end
      end
      MASK: begin
        lim_d  = lim_calc;
        mask_d = mask_calc;
        if (p_q < P_MIN) begin
          key_d   = '0;
          fail_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (rnd_tvalid) begin
          cand_d  = rnd & mask_q;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ((cand_q != '0) && (cand_q <= lim_q)) begin
          key_d   = cand_q;
          fail_d  = 1'b0;
          state_d = DONE;
        end else begin
          tries_d = tries_q + 1'b1;
          if (tries_d == TRIES_MAX) begin
            key_d   = '0;
            fail_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = DRAW;
          end
        end
      end
      DONE: begin
        if (key_tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      lim_q   <= '0;
      mask_q  <= '0;
      cand_q  <= '0;
      key_q   <= '0;
      fail_q  <= 1'b0;
      tries_q <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      lim_q   <= lim_d;
      mask_q  <= mask_d;
      cand_q  <= cand_d;
      key_q   <= key_d;
      fail_q  <= fail_d;
      tries_q <= tries_d;
    end
  end

  assign req_tready = (state_q == IDLE);
  assign rnd_tready = (state_q == DRAW);
  assign key_tvalid = (state_q == DONE);
  assign key        = key_q;
  assign fail       = fail_q;

endmodule

// File: tb/tb_rng_key_sampler.sv
// Directed bench for rng_key_sampler: latency, reject/retry, failure paths,
// backpressure, modulus latching and mid-request reset.
module tb_rng_key_sampler;

  logic        clk;
  logic        rst;
  logic        req_tvalid;
  logic        req_tready;
  logic [63:0] modulus;
  logic        rnd_tvalid;
  logic [63:0] rnd;
  logic        rnd_tready;
  logic        key_tvalid;
  logic        key_tready;
  logic [63:0] key;
  logic        fail;

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;
  int hs0      = 0;
  int lat;
  logic [63:0] word_tab [8];

  rng_key_sampler #(.WIDTH(64), .MAX_TRIES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_tvalid (req_tvalid),
    .req_tready (req_tready),
    .modulus    (modulus),
    .rnd_tvalid (rnd_tvalid),
    .rnd        (rnd),
    .rnd_tready (rnd_tready),
    .key_tvalid (key_tvalid),
    .key_tready (key_tready),
    .key        (key),
    .fail       (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && rnd_tvalid && rnd_tready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; modulus switches to mod_after right after acceptance.
  // lat = edges from the accept edge until key_tvalid is seen high.
  task automatic do_req(input logic [63:0] p, input logic [63:0] mod_after, output int lat_o);
    int idx;
    modulus    = p;
    req_tvalid = 1'b1;
    hs0        = hs_cnt;
    rnd        = word_tab[0];
    step();
    req_tvalid = 1'b0;
    modulus    = mod_after;
    lat_o      = 0;
    for (int n = 0; n < 100; n++) begin
      step();
      lat_o++;
      idx = hs_cnt - hs0;
      if (idx < 8) rnd = word_tab[idx];
      if (key_tvalid) break;
    end
    if (!key_tvalid) check_val("key_tvalid_timeout", {63'd0, key_tvalid}, 64'd1);
  endtask

  task automatic release_key();
    key_tready = 1'b1;
    step();
    key_tready = 1'b0;
    check_val("rel_key_tvalid", {63'd0, key_tvalid}, 64'd0);
    check_val("rel_req_tready", {63'd0, req_tready}, 64'd1);
  endtask

  task automatic fill_tab(input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2);
    for (int i = 0; i < 8; i++) word_tab[i] = 64'd0;
    word_tab[0] = w0;
    word_tab[1] = w1;
    word_tab[2] = w2;
  endtask

  initial begin
    rst        = 1'b0;
    req_tvalid = 1'b0;
    modulus    = 64'd0;
    rnd_tvalid = 1'b0;
    rnd        = 64'd0;
    key_tready = 1'b0;
    for (int i = 0; i < 8; i++) word_tab[i] = 64'd0;
    step();
    step();
    rst = 1'b1;
    step();

    check_val("rst_req_tready", {63'd0, req_tready}, 64'd1);
    check_val("rst_rnd_tready", {63'd0, rnd_tready}, 64'd0);
    check_val("rst_key_tvalid", {63'd0, key_tvalid}, 64'd0);
    check_val("rst_key", key, 64'd0);
    check_val("rst_fail", {63'd0, fail}, 64'd0);

    // 1: p=23, first draw accepted
    rnd_tvalid = 1'b1;
    fill_tab(64'hABCD_0000_0000_0005, 64'd0, 64'd0);
    do_req(64'd23, 64'd23, lat);
    check_val("t1_lat", 64'(lat), 64'd3);
    check_val("t1_key", key, 64'd5);
    check_val("t1_fail", {63'd0, fail}, 64'd0);
    check_val("t1_hs", 64'(hs_cnt - hs0), 64'd1);
    check_val("t1_rnd_tready", {63'd0, rnd_tready}, 64'd0);
    release_key();

    // 2: two rejects (31 > 21, then 0) before 20
    fill_tab(64'hFFFF_0000_0000_001F, 64'h1234_0000_0000_0000, 64'h0000_0000_0000_0034);
    do_req(64'd23, 64'd23, lat);
    check_val("t2_lat", 64'(lat), 64'd7);
    check_val("t2_key", key, 64'd20);
    check_val("t2_fail", {63'd0, fail}, 64'd0);
    check_val("t2_hs", 64'(hs_cnt - hs0), 64'd3);
    release_key();

    // 3: rnd stuck at 0 exhausts MAX_TRIES=4
    fill_tab(64'd0, 64'd0, 64'd0);
    do_req(64'd23, 64'd23, lat);
    check_val("t3_lat", 64'(lat), 64'd9);
    check_val("t3_key", key, 64'd0);
    check_val("t3_fail", {63'd0, fail}, 64'd1);
    check_val("t3_hs", 64'(hs_cnt - hs0), 64'd4);
    release_key();

    // 4: invalid moduli fail straight from MASK
    fill_tab(64'd7, 64'd7, 64'd7);
    do_req(64'd2, 64'd2, lat);
    check_val("t4a_lat", 64'(lat), 64'd1);
    check_val("t4a_fail", {63'd0, fail}, 64'd1);
    check_val("t4a_key", key, 64'd0);
    check_val("t4a_hs", 64'(hs_cnt - hs0), 64'd0);
    release_key();
    do_req(64'd0, 64'd0, lat);
    check_val("t4b_lat", 64'(lat), 64'd1);
    check_val("t4b_fail", {63'd0, fail}, 64'd1);
    check_val("t4b_hs", 64'(hs_cnt - hs0), 64'd0);
    release_key();

    // boundaries: p=3 (lim 1, mask 1) and p=2^64-1 (mask all ones)
    fill_tab(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0);
    do_req(64'd3, 64'd3, lat);
    check_val("p3_key", key, 64'd1);
    check_val("p3_fail", {63'd0, fail}, 64'd0);
    release_key();
    fill_tab(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0);
    do_req(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    check_val("pmax_key", key, 64'hFFFF_FFFF_FFFF_FFFD);
    check_val("pmax_hs", 64'(hs_cnt - hs0), 64'd2);
    release_key();

    // 5: modulus changed to 5 after accept (would give key 3), then backpressure
    fill_tab(64'd7, 64'd0, 64'd0);
    do_req(64'd23, 64'd5, lat);
    check_val("t5_key", key, 64'd7);
    for (int i = 0; i < 10; i++) begin
      req_tvalid = 1'b1;
      step();
      check_val("t5_key_tvalid", {63'd0, key_tvalid}, 64'd1);
      check_val("t5_key_hold", key, 64'd7);
      check_val("t5_fail_hold", {63'd0, fail}, 64'd0);
      check_val("t5_req_tready", {63'd0, req_tready}, 64'd0);
      check_val("t5_rnd_tready", {63'd0, rnd_tready}, 64'd0);
    end
    req_tvalid = 1'b0;
    release_key();

    // 6: reset while in DRAW with no RNG word
    rnd_tvalid = 1'b0;
    modulus    = 64'd23;
    req_tvalid = 1'b1;
    step();
    req_tvalid = 1'b0;
    step();
    check_val("t6_in_draw", {63'd0, rnd_tready}, 64'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_val("t6_req_tready", {63'd0, req_tready}, 64'd1);
    check_val("t6_rnd_tready", {63'd0, rnd_tready}, 64'd0);
    check_val("t6_key", key, 64'd0);
    check_val("t6_fail", {63'd0, fail}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("t6_no_key", {63'd0, key_tvalid}, 64'd0);
    end
    rnd_tvalid = 1'b1;
    fill_tab(64'd9, 64'd0, 64'd0);
    do_req(64'd23, 64'd23, lat);
    check_val("t6_lat", 64'(lat), 64'd3);
    check_val("t6_key_after", key, 64'd9);
    release_key();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
